pulse_tally: RTL and testbench
==============================

# pulse_tally

Downstream consumer for the 1-to-2 demultiplexer stage. Counts rising edges on the two demux outputs (Y and Z channels) in independent saturating counters. On request, atomically snapshots both counts and clears them, then presents the snapshot on a valid/ready output. Used as the measurement stage that checks where the demux routed its input pulses.

## Interface
- WIDTH, 8: counter and snapshot width in bits (2..16)
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous active-low reset
- y_in  in  1  demux Y output (level)
- z_in  in  1  demux Z output (level)
- snap_req  in  1  single-cycle request to capture and clear counts
- out_ready  in  1  consumer accepts snapshot
- out_valid  out  1  snapshot held and valid
- out_y  out  WIDTH  captured Y edge count
- out_z  out  WIDTH  captured Z edge count
- out_ovf  out  2  captured saturation flags, bit0 = Y, bit1 = Z
- busy  out  1  high while in HOLD

Clock is `clock`. Reset is `reset_n`: one clock, reset asynchronous and active-low.

## Operation
- Per channel, a previous-sample register gives `rise = in & ~prev`.
- Counter behaviour on `rise`:
  - increments by 1;
  - saturates at 2^WIDTH-1 and never wraps;
  - an increment attempted at saturation sets that channel's sticky ovf bit.
- FSM states:
  - IDLE: `out_valid` = 0. On `snap_req` = 1, go to HOLD.
  - HOLD: `out_valid` = 1, `busy` = 1. On `out_valid & out_ready`, go to IDLE.
- Capture (taken on the IDLE→HOLD edge):
  - `out_y`/`out_z` ← live counts;
  - `out_ovf` ← live ovf bits;
  - live counters and ovf bits are cleared.
- Rise in the capture cycle: the edge belongs to the new period. The counter is loaded with 1 instead of 0, and the snapshot excludes it.
- `snap_req` in HOLD is ignored, not queued.
- Counting continues uninterrupted during HOLD.
- Output stability: `out_y`, `out_z` and `out_ovf` remain stable for the whole of HOLD and retain their last value after the handshake.
- Y and Z rising in the same cycle are both counted.

## Timing
- Reset values:
  - `out_valid` = 0, `busy` = 0;
  - `out_y` = 0, `out_z` = 0, `out_ovf` = 0;
  - counters, ovf bits and prev registers = 0;
  - state = IDLE.
- Reset mid-HOLD drops the snapshot immediately (asynchronous). Nothing is retained.
- Edge latency without the sync stage: a level first sampled high at edge k updates the counter at edge k.
- `snap_req` sampled at edge k: `out_valid` = 1 after edge k, with the snapshot visible in the same cycle.
- Handshake at edge m (`out_valid & out_ready`): `out_valid` = 0 after edge m. The earliest next capture is edge m+1.
- `out_ready` is ignored while `out_valid` = 0.
- Back-to-back: `snap_req` at edge m+1 is honoured.

## Configuration
- `PULSE_TALLY_SYNC_EN` defined:
  - each input passes through a 2-flop synchronizer (reset to 0) before edge detection;
  - edge latency becomes edge k+2;
  - required when the demux input is a free-running clock unrelated to `clock`.
- `PULSE_TALLY_SYNC_EN` undefined: inputs feed edge detection directly, with latency as above.
- Capture and handshake timing are identical in both builds.

## Structure
- Package `tally_pkg`:
  - state enum {IDLE, HOLD};
  - `TALLY_WIDTH_DEFAULT` = 8;
  - channel index constants `CH_Y` = 0 and `CH_Z` = 1.
- Sub-module `tally_channel`, instantiated twice. It contains:
  - the optional synchronizer;
  - the prev register and rise detect;
  - the saturating counter and sticky ovf bit;
  - a `clear` input, with load-1-on-coincident-rise handling.
- Top level holds the FSM, the snapshot registers and the handshake.

## Test plan
- Reset, then 3 rises on `y_in` and 2 on `z_in`, then `snap_req` -> `out_valid` = 1, `out_y` = 3, `out_z` = 2, `out_ovf` = 0. A second snapshot shows 0/0.
- WIDTH = 4 with 17 Y rises, then snap -> `out_y` = 15, `out_ovf` = 2'b01. The next snapshot has `out_ovf` = 0.
- Y rise in the same cycle as `snap_req` -> the snapshot excludes it. The next snapshot has `out_y` = 1.
- `out_ready` held low for 5 cycles with 2 Z rises during HOLD and a repeated `snap_req` -> outputs stay stable and no second capture occurs. After the handshake, a new snap gives `out_z` = 2.
- Simultaneous Y/Z rises, 4 times -> `out_y` = 4, `out_z` = 4.
- `reset_n` asserted during HOLD -> `out_valid`, `busy` and all outputs are 0 immediately. Run this test with `PULSE_TALLY_SYNC_EN` both defined and undefined, checking +2 edge latency in the defined build.

Source files
------------

// File: rtl/tally_pkg.sv
// Shared types and constants for the pulse_tally measurement block.
// The PULSE_TALLY_SYNC_EN build option is consumed in tally_channel.sv.
package tally_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int TALLY_WIDTH_DEFAULT = 8;

   localparam int CH_Y = 0;
   localparam int CH_Z = 1;

endpackage

// File: rtl/tally_channel.sv
// One counting channel of pulse_tally: optional input synchronizer, rising
// edge detect, saturating edge counter and sticky overflow flag.
// Build option: define PULSE_TALLY_SYNC_EN to insert a 2-flop synchronizer
// ahead of edge detection (edge latency then grows by two clocks).
module tally_channel
   import tally_pkg::*;
#(
   parameter int WIDTH = TALLY_WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             level,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

   logic sampled;
   logic prev;
   logic rise;

`ifdef PULSE_TALLY_SYNC_EN
   logic sync_1;
   logic sync_2;

   // Two-flop synchronizer for levels that are asynchronous to clock
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= level;
         sync_2 <= sync_1;
      end
   end

   assign sampled = sync_2;
`else
   assign sampled = level;
`endif

   // Previous sample of the (possibly synchronized) level for edge detection
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prev <= 1'b0;
      end else begin
         prev <= sampled;
      end
   end

   assign rise = sampled & ~prev;

   // Saturating counter; an edge coinciding with clear starts the new period at 1
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         ovf   <= 1'b0;
      end else if (clear) begin
         count <= rise ? WIDTH'(1) : '0;
         ovf   <= 1'b0;
      end else if (rise) begin
         if (count == COUNT_MAX) begin
            ovf <= 1'b1;
         end else begin
            count <= count + WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/pulse_tally.sv
// pulse_tally: counts rising edges on the demux Y and Z outputs, and on
// request snapshots and clears both counts, presenting the snapshot on a
// valid/ready port. Build option PULSE_TALLY_SYNC_EN (see tally_channel)
// adds input synchronizers; capture and handshake timing are unaffected.
module pulse_tally
   import tally_pkg::*;
#(
   parameter int WIDTH = TALLY_WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             y_in,
   input  logic             z_in,
   input  logic             snap_req,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_y,
   output logic [WIDTH-1:0] out_z,
   output logic [1:0]       out_ovf,
   output logic             busy
);

   state_t           state;
   state_t           next_state;
   logic             capture;
   logic [WIDTH-1:0] live_count [2];
   logic [1:0]       live_ovf;
   logic [1:0]       level;

   assign level[CH_Y] = y_in;
   assign level[CH_Z] = z_in;

   for (genvar ch = 0; ch < 2; ch++) begin : g_channel
      tally_channel #(
         .WIDTH (WIDTH)
      ) u_channel (
         .clock   (clock),
         .reset_n (reset_n),
         .level   (level[ch]),
         .clear   (capture),
         .count   (live_count[ch]),
         .ovf     (live_ovf[ch])
      );
   end

   // State register for the snapshot handshake
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state and outputs; a request while holding a snapshot is dropped
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (snap_req) begin
               capture    = 1'b1;
               next_state = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Snapshot registers load only on capture and otherwise keep their value
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_y   <= '0;
         out_z   <= '0;
         out_ovf <= 2'b00;
      end else if (capture) begin
         out_y   <= live_count[CH_Y];
         out_z   <= live_count[CH_Z];
         out_ovf <= live_ovf;
      end
   end

endmodule

// File: tb/tb_pulse_tally.sv
// Scoreboard testbench for pulse_tally. Two instances (WIDTH 8 and 4) share
// stimulus; expected snapshots are queued per instance when a snap is issued
// and checked by independent monitors when out_valid appears.
// Define PULSE_TALLY_SYNC_EN for both RTL and bench to test the synced build.
module tb_pulse_tally;

   typedef struct {
      logic [7:0] y;
      logic [7:0] z;
      logic [1:0] ovf;
   } snap_t;

`ifdef PULSE_TALLY_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       y_in = 1'b0;
   logic       z_in = 1'b0;
   logic       snap_req = 1'b0;
   logic       out_ready = 1'b1;

   logic       valid8, busy8, valid4, busy4;
   logic [7:0] y8, z8;
   logic [3:0] y4, z4;
   logic [1:0] ovf8, ovf4;

   int checks = 0;
   int errors = 0;

   snap_t q8[$];
   snap_t q4[$];

   pulse_tally #(.WIDTH(8)) dut8 (
      .clock     (clock),
      .reset_n   (reset_n),
      .y_in      (y_in),
      .z_in      (z_in),
      .snap_req  (snap_req),
      .out_ready (out_ready),
      .out_valid (valid8),
      .out_y     (y8),
      .out_z     (z8),
      .out_ovf   (ovf8),
      .busy      (busy8)
   );

   pulse_tally #(.WIDTH(4)) dut4 (
      .clock     (clock),
      .reset_n   (reset_n),
      .y_in      (y_in),
      .z_in      (z_in),
      .snap_req  (snap_req),
      .out_ready (out_ready),
      .out_valid (valid4),
      .out_y     (y4),
      .out_z     (z4),
      .out_ovf   (ovf4),
      .busy      (busy4)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic y, input logic z, input logic snap, input logic ready);
      y_in      = y;
      z_in      = z;
      snap_req  = snap;
      out_ready = ready;
      @(posedge clock);
      #1;
   endtask

   task automatic pushExpected(input int ey8, input int ez8, input int eo8,
                               input int ey4, input int ez4, input int eo4);
      snap_t s;
      s.y = 8'(ey8); s.z = 8'(ez8); s.ovf = 2'(eo8);
      q8.push_back(s);
      s.y = 8'(ey4); s.z = 8'(ez4); s.ovf = 2'(eo4);
      q4.push_back(s);
   endtask

   task automatic settle();
      for (int i = 0; i < LAT + 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic doSnap(input int ey8, input int ez8, input int eo8,
                         input int ey4, input int ez4, input int eo4);
      pushExpected(ey8, ez8, eo8, ey4, ez4, eo4);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pulse(input logic y, input logic z, input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(y, z, 1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   // Monitor for the WIDTH=8 instance
   logic        held8 = 1'b0;
   logic [17:0] last8;
   always @(negedge clock) begin
      snap_t e;
      if (!reset_n) begin
         held8 = 1'b0;
      end else if (valid8) begin
         if (!held8) begin
            checks++;
            if (q8.size() == 0) begin
               errors++;
               $display("[TB] FAIL w8_unexpected_snapshot: got y=%0d z=%0d ovf=%b, expected none", y8, z8, ovf8);
            end else begin
               e = q8.pop_front();
               if (y8 !== e.y || z8 !== e.z || ovf8 !== e.ovf) begin
                  errors++;
                  $display("[TB] FAIL w8_snapshot: got y=%0d z=%0d ovf=%b, expected y=%0d z=%0d ovf=%b",
                           y8, z8, ovf8, e.y, e.z, e.ovf);
               end
            end
            last8 = {y8, z8, ovf8};
            held8 = 1'b1;
         end else begin
            checks++;
            if ({y8, z8, ovf8} !== last8) begin
               errors++;
               $display("[TB] FAIL w8_hold_stable: got %h, expected %h", {y8, z8, ovf8}, last8);
            end
         end
      end else begin
         held8 = 1'b0;
      end
   end

   // Monitor for the WIDTH=4 instance
   logic        held4 = 1'b0;
   logic [9:0]  last4;
   always @(negedge clock) begin
      snap_t e;
      if (!reset_n) begin
         held4 = 1'b0;
      end else if (valid4) begin
         if (!held4) begin
            checks++;
            if (q4.size() == 0) begin
               errors++;
               $display("[TB] FAIL w4_unexpected_snapshot: got y=%0d z=%0d ovf=%b, expected none", y4, z4, ovf4);
            end else begin
               e = q4.pop_front();
               if ({4'h0, y4} !== e.y || {4'h0, z4} !== e.z || ovf4 !== e.ovf) begin
                  errors++;
                  $display("[TB] FAIL w4_snapshot: got y=%0d z=%0d ovf=%b, expected y=%0d z=%0d ovf=%b",
                           y4, z4, ovf4, e.y, e.z, e.ovf);
               end
            end
            last4 = {y4, z4, ovf4};
            held4 = 1'b1;
         end else begin
            checks++;
            if ({y4, z4, ovf4} !== last4) begin
               errors++;
               $display("[TB] FAIL w4_hold_stable: got %h, expected %h", {y4, z4, ovf4}, last4);
            end
         end
      end else begin
         held4 = 1'b0;
      end
   end

   // Directed test sequence
   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_valid8", 16'(valid8), 16'h0);
      checkOutput("reset_busy8",  16'(busy8),  16'h0);
      checkOutput("reset_y8",     16'(y8),     16'h0);
      checkOutput("reset_z8",     16'(z8),     16'h0);
      checkOutput("reset_ovf8",   16'(ovf8),   16'h0);
      checkOutput("reset_valid4", 16'(valid4), 16'h0);
      reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

      // Basic counts, then an empty back-to-back snapshot
      pulse(1'b1, 1'b0, 3);
      pulse(1'b0, 1'b1, 2);
      settle();
      doSnap(3, 2, 0, 3, 2, 0);
      doSnap(0, 0, 0, 0, 0, 0);

      // Saturation: 17 Y edges saturate the 4-bit instance only
      pulse(1'b1, 1'b0, 17);
      settle();
      doSnap(17, 0, 0, 15, 0, 1);
      doSnap(0, 0, 0, 0, 0, 0);

      // Y edge coinciding with capture belongs to the next period
      for (int i = 0; i < LAT; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      pushExpected(0, 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      settle();
      doSnap(1, 0, 0, 1, 0, 0);

      // Consumer stalls; Z edges and a repeated request arrive during HOLD
      pulse(1'b1, 1'b0, 1);
      settle();
      pushExpected(1, 0, 0, 1, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("hold_busy8", 16'(busy8), 16'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("hold_valid4", 16'(valid4), 16'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("after_handshake_valid8", 16'(valid8), 16'h0);
      settle();
      doSnap(0, 2, 0, 0, 2, 0);

      // Simultaneous Y and Z edges
      pulse(1'b1, 1'b1, 4);
      settle();
      doSnap(4, 4, 0, 4, 4, 0);

      // Latency probe A: level high at edge k, snap at edge k+2
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      if (LAT == 2) pushExpected(0, 0, 0, 0, 0, 0);
      else          pushExpected(1, 0, 0, 1, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      settle();
      if (LAT == 2) doSnap(1, 0, 0, 1, 0, 0);
      else          doSnap(0, 0, 0, 0, 0, 0);

      // Latency probe B: level high at edge k, snap at edge k+3
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      pushExpected(1, 0, 0, 1, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      settle();
      doSnap(0, 0, 0, 0, 0, 0);

      // Reset while holding a snapshot drops everything at once
      pulse(1'b1, 1'b0, 2);
      settle();
      pushExpected(2, 0, 0, 2, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midhold_reset_valid8", 16'(valid8), 16'h0);
      checkOutput("midhold_reset_busy8",  16'(busy8),  16'h0);
      checkOutput("midhold_reset_y8",     16'(y8),     16'h0);
      checkOutput("midhold_reset_z8",     16'(z8),     16'h0);
      checkOutput("midhold_reset_ovf8",   16'(ovf8),   16'h0);
      checkOutput("midhold_reset_valid4", 16'(valid4), 16'h0);
      checkOutput("midhold_reset_busy4",  16'(busy4),  16'h0);
      checkOutput("midhold_reset_y4",     16'(y4),     16'h0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      settle();
      doSnap(0, 0, 0, 0, 0, 0);
      settle();

      checkOutput("q8_drained", 16'(q8.size()), 16'h0);
      checkOutput("q4_drained", 16'(q4.size()), 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
